// File: rtl/mux_pipe.sv
// N-to-1 registered mux with a two-entry skid buffer (main + skid) and flush.
// Define MUX_PIPE_ERR_EN to build the sticky out-of-range-select flag on err.
module mux_pipe #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [N*WIDTH-1:0] a_in,
   input  logic [SELW-1:0]    sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err
);

   logic [WIDTH-1:0] r_main_data;
   logic             r_main_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_valid;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_accept;
   logic             w_deliver;

   // One-hot AND-OR select; no matching input leaves the result at zero.
   always_comb begin
      w_sel_data = {WIDTH{1'b0}};
      for (int k = 0; k < N; k++) begin
         w_sel_data = w_sel_data | ({WIDTH{sel == SELW'(k)}} & a_in[k*WIDTH +: WIDTH]);
      end
   end

   assign w_accept  = in_valid & ~r_skid_valid;
   assign w_deliver = r_main_valid & out_ready;

   // Main/skid buffer: flush outranks both accept and deliver.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_data  <= {WIDTH{1'b0}};
         r_main_valid <= 1'b0;
         r_skid_data  <= {WIDTH{1'b0}};
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_main_data  <= {WIDTH{1'b0}};
         r_main_valid <= 1'b0;
         r_skid_data  <= {WIDTH{1'b0}};
         r_skid_valid <= 1'b0;
      end else if (w_deliver) begin
         if (r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main_data  <= w_sel_data;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         if (r_main_valid) begin
            r_skid_data  <= w_sel_data;
            r_skid_valid <= 1'b1;
         end else begin
            r_main_data  <= w_sel_data;
            r_main_valid <= 1'b1;
         end
      end else begin
         r_main_valid <= r_main_valid;
         r_skid_valid <= r_skid_valid;
      end
   end

   assign in_ready  = ~r_skid_valid;
   assign out_data  = r_main_data;
   assign out_valid = r_main_valid;

`ifdef MUX_PIPE_ERR_EN
   logic r_err;
   logic w_sel_oor;

   // Out of range means sel matched none of the N inputs.
   always_comb begin
      w_sel_oor = 1'b1;
      for (int k = 0; k < N; k++) begin
         w_sel_oor = w_sel_oor & (sel != SELW'(k));
      end
   end

   // Sticky until reset; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_accept && w_sel_oor) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe (WIDTH=32, N=3): an ordered queue of expected
// words stands in for the buffer; a negedge monitor checks outputs against it.
module tb_mux_pipe;
   localparam int WIDTH = 32;
   localparam int N     = 3;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               flush;
   logic [N*WIDTH-1:0] a_in;
   logic [SELW-1:0]    sel;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic               err;

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;
   logic [WIDTH-1:0] q[$];
   logic             err_exp = 1'b0;

   mux_pipe #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .a_in(a_in), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .err(err)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [WIDTH-1:0] ref_sel(logic [N*WIDTH-1:0] a, logic [SELW-1:0] s);
      int idx = int'(s);
      if (idx < N) return a[idx*WIDTH +: WIDTH];
      return '0;
   endfunction

   // Occupancy of the expected queue decides out_valid and in_ready.
   always @(negedge clk) begin
      if (reset) begin
         chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
         chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
         chk("err", {63'd0, err}, {63'd0, err_exp});
         if (out_valid && q.size() > 0) chk("out_data", {32'd0, out_data}, {32'd0, q[0]});
         if (in_valid && in_ready && int'(sel) >= N) begin
`ifdef MUX_PIPE_ERR_EN
            err_exp = 1'b1;
`endif
         end
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() > 0) begin
               void'(q.pop_front());
               n_out++;
            end
            if (in_valid && in_ready) q.push_back(ref_sel(a_in, sel));
         end
      end
   end

   task automatic cyc(input logic v, input logic [SELW-1:0] s, input logic [N*WIDTH-1:0] a,
                      input logic ordy, input logic fl);
      in_valid  = v;
      sel       = s;
      a_in      = a;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
      chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int n0;
      logic [N*WIDTH-1:0] a;
      logic [SELW-1:0]    s;
      logic               fl;
      reset = 1'b0; flush = 1'b0; a_in = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_err", {63'd0, err}, 64'd0);
      reset = 1'b1;

      // Single transfer, sel=1.
      cyc(1'b1, 2'd1, {32'h33, 32'h22, 32'h11}, 1'b1, 1'b0);
      chk("sel1_data", {32'd0, out_data}, 64'h22);
      chk("sel1_valid", {63'd0, out_valid}, 64'd1);
      cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
      chk("sel1_drop", {63'd0, out_valid}, 64'd0);

      // Out-of-range select yields zero; err follows the build option.
      cyc(1'b1, 2'd3, {32'h33, 32'h22, 32'h11}, 1'b1, 1'b0);
      chk("oor_data", {32'd0, out_data}, 64'h0);
      cyc(1'b0, 2'd0, '0, 1'b1, 1'b1);
`ifdef MUX_PIPE_ERR_EN
      chk("oor_err_after_flush", {63'd0, err}, 64'd1);
`else
      chk("oor_err_off", {63'd0, err}, 64'd0);
`endif

      // Back-to-back accepts against a stalled consumer fill the skid entry.
      cyc(1'b1, 2'd0, {32'h0, 32'h0, 32'hA}, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, {32'hB, 32'h0, 32'h0}, 1'b0, 1'b0);
      chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
      chk("skid_hold_a", {32'd0, out_data}, 64'hA);
      cyc(1'b0, 2'd0, '0, 1'b0, 1'b0);
      chk("stall_hold_a", {32'd0, out_data}, 64'hA);
      cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
      chk("drain_b", {32'd0, out_data}, 64'hB);
      chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
      drain();

      // Eight consecutive accepts stream out one per cycle.
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         a = {$urandom, $urandom, $urandom};
         cyc(1'b1, SELW'(i % N), a, 1'b1, 1'b0);
         chk("burst_data", {32'd0, out_data}, {32'd0, a[(i % N)*WIDTH +: WIDTH]});
      end
      drain();
      chk("burst_count", n_out - n0, 64'd8);

      // Flush with both entries full discards the offered word too.
      cyc(1'b1, 2'd0, {32'h0, 32'h0, 32'h1}, 1'b0, 1'b0);
      cyc(1'b1, 2'd0, {32'h0, 32'h0, 32'h2}, 1'b0, 1'b0);
      cyc(1'b1, 2'd0, {32'h0, 32'h0, 32'hDEAD}, 1'b0, 1'b1);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (3) cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

      // Asynchronous reset pulse between clock edges.
      cyc(1'b1, 2'd2, {32'h5A5A, 32'h0, 32'h0}, 1'b0, 1'b0);
      in_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      chk("async_out_valid", {63'd0, out_valid}, 64'd0);
      chk("async_out_data", {32'd0, out_data}, 64'd0);
      chk("async_in_ready", {63'd0, in_ready}, 64'd1);
      q.delete();
      err_exp = 1'b0;
      #1 reset = 1'b1;
      cyc(1'b1, 2'd0, {32'h0, 32'h0, 32'h77}, 1'b1, 1'b0);
      chk("post_reset_data", {32'd0, out_data}, 64'h77);

      // Randomized traffic, checked by the monitor.
      for (int i = 0; i < 400; i++) begin
         a  = {$urandom, $urandom, $urandom};
         fl = ($urandom_range(0, 31) == 0);
         s  = SELW'($urandom_range(0, 3));
         if (fl && int'(s) >= N) s = 2'd0;
         cyc($urandom_range(0, 3) != 0, s, a, $urandom_range(0, 9) < 7, fl);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
